ir_prefetch_queue: RTL and testbench

//   Parametrised instruction register with a prefetch FIFO. It buffers fetched

---
 rtl/ir_prefetch_queue.sv | 84 ++++++++
 tb/tb_ir_prefetch_queue.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ir_prefetch_queue.sv
// Purpose: instruction register backed by a small prefetch FIFO of {instr, pc} pairs.
// Latency: a push at edge k is visible on IRInstruction/IRPC after edge k (1 cycle), with no bypass.
// Backpressure: fill_ready drops while the queue is full; the head holds while IRWre is low.
//
// Ports:
//   CLK, Reset                clock and asynchronous active-high reset
//   flush                     synchronous discard of every queued entry
//   fill_valid/fill_ready     fetch-side handshake carrying fill_instr/fill_pc
//   IRWre                     decode consumes the head entry
//   ir_valid, IRInstruction,  head entry; the data fields read as 0 while empty
//   IRPC
//   count                     occupancy, 0..DEPTH
module ir_prefetch_queue #(
  parameter  int DATA_W = 32,
  parameter  int PC_W   = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              flush,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_instr,
  input  logic [PC_W-1:0]   fill_pc,
  output logic              fill_ready,
  input  logic              IRWre,
  output logic              ir_valid,
  output logic [DATA_W-1:0] IRInstruction,
  output logic [PC_W-1:0]   IRPC,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;
  entry_t             head;

  // fill_ready depends on count alone, so a pop in the same cycle cannot
  // open a slot: a full queue never pushes through.
  assign fill_ready = (count != CNT_W'(DEPTH));
  assign ir_valid   = (count != '0);

  assign push = fill_valid & fill_ready & ~flush;
  assign pop  = IRWre & ir_valid & ~flush;

  // The data fields are gated by ir_valid so that stale storage is never visible.
  // count is reset asynchronously, so the outputs drop to 0 as soon as
  // Reset asserts, without waiting for an edge.
  assign head          = mem[rd_ptr];
  assign IRInstruction = ir_valid ? head.instr : '0;
  assign IRPC          = ir_valid ? head.pc    : '0;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage has no reset. A slot is written only when it is not the live
  // head of a non-empty queue, so the head stays stable while it is held.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{instr: fill_instr, pc: fill_pc};
  end

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed bench for ir_prefetch_queue (DEPTH=4, 32-bit instruction and PC).
// Inputs change 1 time unit after each rising edge, and the outputs are checked at that same point.
module tb_ir_prefetch_queue;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        flush = 1'b0;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_instr = '0;
  logic [31:0] fill_pc = '0;
  logic        fill_ready;
  logic        IRWre = 1'b0;
  logic        ir_valid;
  logic [31:0] IRInstruction;
  logic [31:0] IRPC;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  ir_prefetch_queue #(.DATA_W(32), .PC_W(32), .DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .flush(flush),
    .fill_valid(fill_valid), .fill_instr(fill_instr), .fill_pc(fill_pc),
    .fill_ready(fill_ready), .IRWre(IRWre), .ir_valid(ir_valid),
    .IRInstruction(IRInstruction), .IRPC(IRPC), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [2:0] cnt);
    check({tag, ".valid"}, 64'(ir_valid), 64'(v));
    check({tag, ".instr"}, 64'(IRInstruction), 64'(ins));
    check({tag, ".pc"}, 64'(IRPC), 64'(pc));
    check({tag, ".count"}, 64'(count), 64'(cnt));
  endtask

  task automatic set_fill(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    fill_valid = v;
    fill_instr = ins;
    fill_pc    = pc;
  endtask

  initial begin
    // 1: reset state, both while Reset is held and after it is released
    #12;
    head("rst_held", 1'b0, 32'h0, 32'h0, 3'd0);
    check("rst_held.ready", 64'(fill_ready), 64'd1);
    Reset = 1'b0;
    step();
    head("rst", 1'b0, 32'h0, 32'h0, 3'd0);
    check("rst.ready", 64'(fill_ready), 64'd1);

    // 2: a single push, then the head holds while IRWre is low, even with a second push behind it
    set_fill(1'b1, 32'h2008_0005, 32'h0);
    step();
    set_fill(1'b0, 32'h0, 32'h0);
    head("push1", 1'b1, 32'h2008_0005, 32'h0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      head("hold", 1'b1, 32'h2008_0005, 32'h0, 3'd1);
    end
    set_fill(1'b1, 32'h99, 32'h4);
    step();
    set_fill(1'b0, 32'h0, 32'h0);
    head("hold_push", 1'b1, 32'h2008_0005, 32'h0, 3'd2);
    IRWre = 1'b1;
    step();
    head("pop_a", 1'b1, 32'h99, 32'h4, 3'd1);
    step();
    head("pop_b", 1'b0, 32'h0, 32'h0, 3'd0);
    IRWre = 1'b0;

    // 3: fill to full, then a refused push (also refused with a same-cycle pop), then drain
    set_fill(1'b1, 32'h11, 32'h0); step();
    set_fill(1'b1, 32'h22, 32'h4); step();
    set_fill(1'b1, 32'h33, 32'h8); step();
    set_fill(1'b1, 32'h44, 32'hC); step();
    head("full", 1'b1, 32'h11, 32'h0, 3'd4);
    check("full.ready", 64'(fill_ready), 64'd0);
    set_fill(1'b1, 32'h55, 32'h10);
    step();
    head("full_refuse", 1'b1, 32'h11, 32'h0, 3'd4);
    IRWre = 1'b1;
    step();
    head("full_pop_push", 1'b1, 32'h22, 32'h4, 3'd3);
    set_fill(1'b0, 32'h0, 32'h0);
    step();
    head("drain3", 1'b1, 32'h33, 32'h8, 3'd2);
    step();
    head("drain4", 1'b1, 32'h44, 32'hC, 3'd1);
    step();
    head("drained", 1'b0, 32'h0, 32'h0, 3'd0);
    check("drained.ready", 64'(fill_ready), 64'd1);
    step();
    head("pop_empty", 1'b0, 32'h0, 32'h0, 3'd0);
    IRWre = 1'b0;

    // 4: at count=2, push and pop together for 10 cycles; the pointers wrap around several times
    set_fill(1'b1, 32'h100, 32'h0); step();
    set_fill(1'b1, 32'h101, 32'h4); step();
    head("steady_pre", 1'b1, 32'h100, 32'h0, 3'd2);
    IRWre = 1'b1;
    for (int j = 0; j < 10; j++) begin
      set_fill(1'b1, 32'h102 + 32'(j), 32'(4 * (j + 2)));
      step();
      head($sformatf("steady%0d", j), 1'b1, 32'h101 + 32'(j), 32'(4 * (j + 1)), 3'd2);
    end
    IRWre = 1'b0;

    // 5: flush at count=3 with a same-cycle push and pop, then a fresh push
    set_fill(1'b1, 32'h10C, 32'h30);
    step();
    head("pre_flush", 1'b1, 32'h10A, 32'h28, 3'd3);
    flush = 1'b1;
    IRWre = 1'b1;
    set_fill(1'b1, 32'hBEEF, 32'h50);
    step();
    flush = 1'b0;
    IRWre = 1'b0;
    set_fill(1'b0, 32'h0, 32'h0);
    head("flushed", 1'b0, 32'h0, 32'h0, 3'd0);
    set_fill(1'b1, 32'hDEAD, 32'h40);
    step();
    set_fill(1'b0, 32'h0, 32'h0);
    head("post_flush", 1'b1, 32'hDEAD, 32'h40, 3'd1);

    // 6: reset pulse mid-cycle at count=3, and the queue behaves as empty afterwards
    set_fill(1'b1, 32'hE1, 32'h44); step();
    set_fill(1'b1, 32'hE2, 32'h48); step();
    set_fill(1'b0, 32'h0, 32'h0);
    head("pre_reset", 1'b1, 32'hDEAD, 32'h40, 3'd3);
    #2 Reset = 1'b1;
    #1;
    head("async_rst", 1'b0, 32'h0, 32'h0, 3'd0);
    check("async_rst.ready", 64'(fill_ready), 64'd1);
    #2 Reset = 1'b0;
    IRWre = 1'b1;
    step();
    head("rst_pop_empty", 1'b0, 32'h0, 32'h0, 3'd0);
    IRWre = 1'b0;
    set_fill(1'b1, 32'h77, 32'h8);
    step();
    set_fill(1'b0, 32'h0, 32'h0);
    head("rst_first_push", 1'b1, 32'h77, 32'h8, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
